// File: rtl/btn_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_bank
// Purpose  : Front-panel push-button conditioning. Each raw, bouncy button
//            input is synchronized, debounced into a clean level and turned
//            into a single-cycle press pulse. A shared hold-to-repeat timer
//            re-pulses every held channel while the level vector is steady.
// Ports    : clk        - system clock (rising edge)
//            rst        - asynchronous, active-high reset
//            btn_raw    - raw asynchronous button inputs, active high
//            repeat_en  - enables auto-repeat, sampled every cycle
//            btn_level  - registered debounced level per channel
//            btn_press  - registered one-cycle press/repeat pulse per channel
//            any_press  - OR of the btn_press register bits
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce_bank #(
    parameter int N_BTN      = 7,
    parameter int DEB_CYCLES = 328,
    parameter int REPEAT_DLY = 16384,
    parameter int REPEAT_PER = 3277
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             any_press
);

    localparam int c_CW   = $clog2(DEB_CYCLES + 1);
    localparam int c_TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEB_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_TW-1:0] c_DLY_LAST = c_TW'(REPEAT_DLY - 1);
    localparam logic [c_TW-1:0] c_PER_LAST = c_TW'(REPEAT_PER - 1);
    localparam logic [c_TW-1:0] c_TMR_ONE  = c_TW'(1);

    // Repeat phase encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] w_lvl_nxt;   // level each channel will hold after this edge
    logic [N_BTN-1:0] w_rise;
    logic [1:0]       r_phase;
    logic [c_TW-1:0]  r_timer;

    // ------------------------------------------------------------------
    // Per-channel debounce: the synchronized input must disagree with the
    // stable level for DEB_CYCLES consecutive cycles; any agreement (a
    // bounce back) clears the partial count.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        logic [c_CW-1:0] r_cnt;
        logic            r_lvl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_s2[gi] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_lvl <= r_s2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end

        assign w_lvl_nxt[gi] = ((r_s2[gi] != r_lvl) && (r_cnt == c_CNT_LAST)) ? r_s2[gi] : r_lvl;
        assign btn_level[gi] = r_lvl;
    end : g_chan

    // A fresh press is a 0->1 transition being committed on this edge, so the
    // pulse lines up with the first cycle the level reads 1.
    assign w_rise = w_lvl_nxt & ~btn_level;

    // ------------------------------------------------------------------
    // Synchronizer, press register and shared auto-repeat timer.
    // Any change of the level vector restarts the timer; in DELAY the timer
    // saturates at its terminal value while repeat is disabled so that
    // re-enabling fires on the very next edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_press <= '0;
            r_phase <= c_IDLE;
            r_timer <= '0;
        end else begin
            r_s1    <= btn_raw;
            r_s2    <= r_s1;
            r_press <= w_rise;

            if (w_lvl_nxt != btn_level) begin
                r_timer <= '0;
                r_phase <= (|w_lvl_nxt) ? c_DELAY : c_IDLE;
            end else begin
                case (r_phase)
                    c_IDLE: begin
                        r_timer <= '0;
                    end
                    c_DELAY: begin
                        if (r_timer == c_DLY_LAST) begin
                            if (repeat_en) begin
                                r_press <= w_rise | btn_level;
                                r_phase <= c_REPEAT;
                                r_timer <= '0;
                            end
                        end else begin
                            r_timer <= r_timer + c_TMR_ONE;
                        end
                    end
                    c_REPEAT: begin
                        if (r_timer == c_PER_LAST) begin
                            r_timer <= '0;
                            if (repeat_en) begin
                                r_press <= w_rise | btn_level;
                            end
                        end else begin
                            r_timer <= r_timer + c_TMR_ONE;
                        end
                    end
                    default: begin
                        r_phase <= c_IDLE;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_press = r_press;
    assign any_press = |r_press;

endmodule : btn_debounce_bank
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce_bank
// Purpose  : Directed self-checking bench for btn_debounce_bank with
//            DEB_CYCLES=4, REPEAT_DLY=10, REPEAT_PER=3, N_BTN=7.
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_debounce_bank;

    localparam int c_N = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [c_N-1:0] btn_raw = '0;
    logic           repeat_en = 1'b0;
    logic [c_N-1:0] btn_level;
    logic [c_N-1:0] btn_press;
    logic           any_press;

    int n_cmp = 0;
    int n_bad = 0;

    btn_debounce_bank #(
        .N_BTN(c_N), .DEB_CYCLES(4), .REPEAT_DLY(10), .REPEAT_PER(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press), .any_press(any_press)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL reset_level act=%b exp=%b", btn_level, 7'b0); end
        n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL reset_press act=%b exp=%b", btn_press, 7'b0); end
        n_cmp++; if (any_press !== 1'b0) begin n_bad++; $display("FAIL reset_any act=%b exp=%b", any_press, 1'b0); end
        tick(2);
        rst = 1'b0;
        tick(3);
        n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL reset_idle_press act=%b exp=%b", btn_press, 7'b0); end
    endtask

    task automatic test_clean_press();
        repeat_en = 1'b0;
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL clean_early_level k=%0d act=%b exp=%b", k, btn_level, 7'b0); end
        end
        tick(1);
        n_cmp++; if (btn_level !== 7'b0000100) begin n_bad++; $display("FAIL clean_level act=%b exp=%b", btn_level, 7'b0000100); end
        n_cmp++; if (btn_press !== 7'b0000100) begin n_bad++; $display("FAIL clean_press act=%b exp=%b", btn_press, 7'b0000100); end
        n_cmp++; if (any_press !== 1'b1) begin n_bad++; $display("FAIL clean_any act=%b exp=%b", any_press, 1'b1); end
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL clean_held_press k=%0d act=%b exp=%b", k, btn_press, 7'b0); end
        end
        btn_raw[2] = 1'b0;
        tick(5);
        n_cmp++; if (btn_level !== 7'b0000100) begin n_bad++; $display("FAIL clean_rel_early act=%b exp=%b", btn_level, 7'b0000100); end
        tick(1);
        n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL clean_rel_level act=%b exp=%b", btn_level, 7'b0); end
        n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL clean_rel_press act=%b exp=%b", btn_press, 7'b0); end
        tick(4);
    endtask

    task automatic test_bounce();
        repeat_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            btn_raw[0] = (k % 2 == 0);
            tick(1);
            n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL bounce_toggle_level k=%0d act=%b exp=%b", k, btn_level, 7'b0); end
        end
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_cmp++; if (btn_press !== 7'b0 || btn_level !== 7'b0) begin n_bad++; $display("FAIL bounce_early k=%0d act=%b/%b exp=0", k, btn_level, btn_press); end
        end
        tick(1);
        n_cmp++; if (btn_press !== 7'b0000001) begin n_bad++; $display("FAIL bounce_press act=%b exp=%b", btn_press, 7'b0000001); end
        tick(1);
        n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL bounce_single act=%b exp=%b", btn_press, 7'b0); end
        btn_raw[0] = 1'b0;
        tick(10);
        n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL bounce_rel act=%b exp=%b", btn_level, 7'b0); end
    endtask

    task automatic test_auto_repeat();
        logic [c_N-1:0] exp;
        repeat_en = 1'b1;
        btn_raw[5] = 1'b1;
        tick(6);
        n_cmp++; if (btn_press !== 7'b0100000) begin n_bad++; $display("FAIL rep_first act=%b exp=%b", btn_press, 7'b0100000); end
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp = (k == 10 || k == 13 || k == 16) ? 7'b0100000 : 7'b0;
            n_cmp++; if (btn_press !== exp) begin n_bad++; $display("FAIL rep_seq T+%0d act=%b exp=%b", k, btn_press, exp); end
        end
        // Level is still 1 until 6 edges after release, so one more period fires.
        btn_raw[5] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp = (k == 3) ? 7'b0100000 : 7'b0;
            n_cmp++; if (btn_press !== exp) begin n_bad++; $display("FAIL rep_release k=%0d act=%b exp=%b", k, btn_press, exp); end
        end
        n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL rep_rel_level act=%b exp=%b", btn_level, 7'b0); end
    endtask

    task automatic test_multi();
        logic [c_N-1:0] exp;
        repeat_en = 1'b1;
        btn_raw[1] = 1'b1;
        tick(6);
        n_cmp++; if (btn_press !== 7'b0000010) begin n_bad++; $display("FAIL multi_first act=%b exp=%b", btn_press, 7'b0000010); end
        tick(3);
        btn_raw[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL multi_wait k=%0d act=%b exp=%b", k, btn_press, 7'b0); end
        end
        tick(1);
        n_cmp++; if (btn_press !== 7'b0001000) begin n_bad++; $display("FAIL multi_second act=%b exp=%b", btn_press, 7'b0001000); end
        n_cmp++; if (btn_level !== 7'b0001010) begin n_bad++; $display("FAIL multi_level act=%b exp=%b", btn_level, 7'b0001010); end
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            exp = (k == 10) ? 7'b0001010 : 7'b0;
            n_cmp++; if (btn_press !== exp) begin n_bad++; $display("FAIL multi_rep k=%0d act=%b exp=%b", k, btn_press, exp); end
        end
        btn_raw[1] = 1'b0;
        btn_raw[3] = 1'b0;
        tick(20);
        n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL multi_rel act=%b exp=%b", btn_level, 7'b0); end
    endtask

    task automatic test_async_reset();
        repeat_en = 1'b1;
        btn_raw[4] = 1'b1;
        tick(6);
        n_cmp++; if (btn_press !== 7'b0010000) begin n_bad++; $display("FAIL arst_first act=%b exp=%b", btn_press, 7'b0010000); end
        tick(10);
        n_cmp++; if (btn_press !== 7'b0010000) begin n_bad++; $display("FAIL arst_rep act=%b exp=%b", btn_press, 7'b0010000); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (btn_level !== 7'b0) begin n_bad++; $display("FAIL arst_level act=%b exp=%b", btn_level, 7'b0); end
        n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL arst_press act=%b exp=%b", btn_press, 7'b0); end
        n_cmp++; if (any_press !== 1'b0) begin n_bad++; $display("FAIL arst_any act=%b exp=%b", any_press, 1'b0); end
        tick(2);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_cmp++; if (btn_level !== 7'b0 || btn_press !== 7'b0) begin n_bad++; $display("FAIL arst_requal k=%0d act=%b/%b exp=0", k, btn_level, btn_press); end
        end
        tick(1);
        n_cmp++; if (btn_press !== 7'b0010000) begin n_bad++; $display("FAIL arst_after act=%b exp=%b", btn_press, 7'b0010000); end
        btn_raw[4] = 1'b0;
        tick(20);
    endtask

    task automatic test_gating();
        logic [c_N-1:0] exp;
        repeat_en = 1'b0;
        btn_raw[6] = 1'b1;
        tick(6);
        n_cmp++; if (btn_press !== 7'b1000000) begin n_bad++; $display("FAIL gate_first act=%b exp=%b", btn_press, 7'b1000000); end
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            n_cmp++; if (btn_press !== 7'b0) begin n_bad++; $display("FAIL gate_off k=%0d act=%b exp=%b", k, btn_press, 7'b0); end
        end
        repeat_en = 1'b1;
        tick(1);
        n_cmp++; if (btn_press !== 7'b1000000) begin n_bad++; $display("FAIL gate_resume act=%b exp=%b", btn_press, 7'b1000000); end
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp = (k == 3 || k == 6) ? 7'b1000000 : 7'b0;
            n_cmp++; if (btn_press !== exp) begin n_bad++; $display("FAIL gate_rep k=%0d act=%b exp=%b", k, btn_press, exp); end
        end
        btn_raw[6] = 1'b0;
        tick(20);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_multi();
        test_async_reset();
        test_gating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_btn_debounce_bank
`default_nettype wire

// File: doc/btn_debounce_bank.md
Name: btn_debounce_bank

Overview:
- Upstream conditioning stage for the die-roller front panel.
- Takes the raw, bouncy push-button inputs from ui_in and produces two outputs per button:
  - a clean debounced level;
  - a single-cycle press pulse, with optional hold-to-repeat.
- The BCD roll/decrement counter consumes btn_press instead of raw levels. One held button therefore advances the counter once, or at the repeat rate, rather than every clock.
- Runs on the 32768 Hz system clock.

Parameters:
- N_BTN, 7: number of button channels (ui_in[6:0]).
- DEB_CYCLES, 328: consecutive cycles a synchronized input must differ from the stable level before it is accepted (about 10 ms). Legal range 2..1023.
- REPEAT_DLY, 16384: cycles from a stable press (or any stable-vector change) to the first auto-repeat pulse (0.5 s). Must be ≥ 2.
- REPEAT_PER, 3277: cycles between subsequent auto-repeat pulses (about 100 ms). Must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  N_BTN  raw button inputs, asynchronous, active high.
- repeat_en  in  1  enables auto-repeat; sampled every cycle.
- btn_level  out  N_BTN  debounced stable level per channel.
- btn_press  out  N_BTN  one-cycle press/repeat pulse per channel.
- any_press  out  1  OR of btn_press.

Behaviour:
- **Reset:** clk and rst are used as named above; reset is asynchronous and active-high. While rst=1 (asserted or released at any point), all of the following are 0 and stay 0:
  - synchronizer flops, debounce counters, btn_level, btn_press, any_press, repeat timer;
  - repeat phase = IDLE.
  - Reset mid-debounce discards partial counts. A button still held after reset release must re-qualify for the full DEB_CYCLES before it is reported.
- **Synchronizer:** each btn_raw bit passes through a 2-flop synchronizer (s1→s2).
- **Debounce, per channel, independent counter of width clog2(DEB_CYCLES+1):**
  - If s2 == btn_level: counter ← 0.
  - Else if counter == DEB_CYCLES-1: btn_level ← s2 and counter ← 0.
  - Else: counter ← counter+1.
  - A single-cycle glitch (bounce) back to the stable level resets the count.
  - Latency: a clean input change is reflected on btn_level at the (DEB_CYCLES+2)th rising edge after the change is setup-met at s1.
- **Press pulse:**
  - btn_press[i]=1 for exactly one cycle, coincident with the first cycle btn_level[i] reads 1.
  - No pulse on release (1→0).
  - Several channels qualifying on the same edge pulse together.
- **Auto-repeat:** one shared timer, width clog2(max(REPEAT_DLY, REPEAT_PER)+1), with phases IDLE, DELAY, REPEAT.
  - Any change of the btn_level vector, including release of one of several buttons, restarts the timer at 0 in DELAY if the new vector is non-zero, or goes to IDLE if it is zero.
  - DELAY: timer increments. At timer == REPEAT_DLY-1, if repeat_en=1, pulse btn_press on every channel with btn_level=1, then go to REPEAT with timer 0. If repeat_en=0, stay in DELAY with the timer saturated and emit no pulse.
  - REPEAT: at timer == REPEAT_PER-1, pulse the held channels and set timer ← 0.
  - repeat_en=0 in REPEAT holds the phase and suppresses pulses. Re-asserting repeat_en resumes at the next period boundary.
  - A fresh-press pulse and a repeat pulse on the same edge OR together; each channel pulses at most once per cycle.
- **Registers:** btn_level and btn_press are registered outputs. any_press is the combinational OR of the btn_press register bits.

Test Plan (bench uses DEB_CYCLES=4, REPEAT_DLY=10, REPEAT_PER=3, N_BTN=7):
- **Clean press:** btn_raw[2] 0→1 and held, repeat_en=0.
  - btn_level[2] rises on edge 6 after the change.
  - btn_press=7'b0000100 for exactly that one cycle, any_press=1.
  - No further pulses while held. Release → btn_level[2] falls 6 edges later, no pulse.
- **Bounce rejection:** btn_raw[0] toggles 1,0,1,0 on successive cycles, then holds 1.
  - No btn_level change during toggling.
  - A single press pulse arrives 6 edges after the final stable 1.
- **Auto-repeat:** repeat_en=1, hold btn_raw[5].
  - Pulse at qualification (cycle T).
  - Repeat pulses at T+10, T+13, T+16.
  - Release → pulses stop; phase IDLE.
- **Multi-button change:** hold btn[1], then btn[3] qualifies mid-DELAY.
  - Pulse on bit 3 only.
  - Timer restarts; the next repeat pulses both bits (7'b0001010) 10 cycles later.
- **Async reset mid-operation:** assert rst while btn[4] is held in REPEAT, between edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - Release rst with btn[4] still held → btn_press[4] pulses at edge 6 after release.
- **repeat_en gating:** hold btn[6] with repeat_en=0 for 30 cycles → only the initial pulse. Set repeat_en=1 → pulse within 1 cycle, since DELAY is saturated, then every 3 cycles.
